// File: rtl/ucsbece154a_muldiv_pkg.sv
// ucsbece154a_muldiv_pkg: op codes, FSM states and counter sizing for the multiply/divide unit
package ucsbece154a_muldiv_pkg;
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;
  function automatic int md_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/ucsbece154a_muldiv_if.sv
// ucsbece154a_muldiv_if: request, MTHI/MTLO and HI/LO result bundle between controller and muldiv
interface ucsbece154a_muldiv_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             we_hi_i;
  logic             we_lo_i;
  logic [WIDTH-1:0] wd_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  modport master (output start_i, op_i, a_i, b_i, we_hi_i, we_lo_i, wd_i,
                  input  busy_o, done_o, hi_o, lo_o);
  modport slave  (input  start_i, op_i, a_i, b_i, we_hi_i, we_lo_i, wd_i,
                  output busy_o, done_o, hi_o, lo_o);
endinterface

// File: rtl/ucsbece154a_muldiv.sv
// ucsbece154a_muldiv: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers
module ucsbece154a_muldiv
  import ucsbece154a_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n_i,
  ucsbece154a_muldiv_if.slave md
);
  localparam int CW = md_cnt_w(WIDTH);
  md_state_e          state, state_n;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, busy, done;
  logic               sgn, op_div, a_neg, b_neg;
  logic [WIDTH-1:0]   acc, mq, bm, hi, lo, a_mag, b_mag;
  logic [WIDTH:0]     add_a, add_b;
  logic [WIDTH+1:0]   sum;
  logic [2*WIDTH-1:0] prod_fix;
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_n;
  always_comb begin
    state_n = S_IDLE;
    state_n = state == S_IDLE ? (md.start_i ? S_RUN : S_IDLE)
            : state == S_RUN  ? (cnt == CW'(WIDTH-1) ? S_FIX : S_RUN)
            : S_IDLE;
  end
  // Operand conditioning at launch: signed ops iterate on magnitudes
  always_comb begin
    sgn    = (md.op_i == MD_MULT) || (md.op_i == MD_DIV);
    op_div = (md.op_i == MD_DIV) || (md.op_i == MD_DIVU);
    a_neg  = sgn & md.a_i[WIDTH-1];
    b_neg  = sgn & md.b_i[WIDTH-1];
    a_mag  = a_neg ? -md.a_i : md.a_i;
    b_mag  = b_neg ? -md.b_i : md.b_i;
  end
  // Shared adder: add for multiply, carry-out doubles as the no-borrow flag for divide
  always_comb begin
    add_a    = is_div ? {acc, mq[WIDTH-1]} : {1'b0, acc};
    add_b    = is_div ? ~{1'b0, bm} : (mq[0] ? {1'b0, bm} : '0);
    sum      = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(is_div);
    prod_fix = neg_res ? -{acc, mq} : {acc, mq};
  end
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      mq      <= '0;
      bm      <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      busy <= state_n != S_IDLE;
      done <= state == S_FIX;
      if (state == S_IDLE) begin
        if (md.we_hi_i) hi <= md.wd_i;
        if (md.we_lo_i) lo <= md.wd_i;
        if (md.start_i) begin
          is_div  <= op_div;
          // A zero divisor keeps the quotient all ones regardless of sign
          neg_res <= (a_neg ^ b_neg) & (~op_div | (|md.b_i));
          neg_rem <= a_neg;
          acc     <= '0;
          mq      <= a_mag;
          bm      <= b_mag;
          cnt     <= '0;
        end
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          acc <= sum[WIDTH+1] ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
          mq  <= {mq[WIDTH-2:0], sum[WIDTH+1]};
        end else begin
          acc <= sum[WIDTH:1];
          mq  <= {sum[0], mq[WIDTH-1:1]};
        end
      end else begin
        hi <= is_div ? (neg_rem ? -acc : acc) : prod_fix[2*WIDTH-1:WIDTH];
        lo <= is_div ? (neg_res ? -mq : mq) : prod_fix[WIDTH-1:0];
      end
    end
  assign md.busy_o = busy;
  assign md.done_o = done;
  assign md.hi_o   = hi;
  assign md.lo_o   = lo;
endmodule

// File: tb/tb_ucsbece154a_muldiv.sv
// tb_ucsbece154a_muldiv: directed-vector self-checking bench for the multiply/divide unit
module tb_ucsbece154a_muldiv;
  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  int   errors = 0;
  int   checks = 0;
  ucsbece154a_muldiv_if #(.WIDTH(32)) md ();
  ucsbece154a_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst_n_i(rst_n_i), .md(md));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Launch at a negedge, then follow the op through to done with a cycle budget
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic wlo);
    int lat = 0;
    int busy_cnt = 0;
    int both = 0;
    @(negedge clk);
    md.start_i = 1'b1;
    md.op_i    = op;
    md.a_i     = a;
    md.b_i     = b;
    md.we_lo_i = wlo;
    md.wd_i    = 32'h0000CAFE;
    @(posedge clk);
    #1;
    md.start_i = 1'b0;
    md.we_lo_i = 1'b0;
    if (wlo) chk({tag, "_mtlo_at_start"}, md.lo_o, 32'h0000CAFE);
    while (!md.done_o && lat < 40) begin
      if (md.busy_o) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (md.busy_o && md.done_o) both++;
    chk({tag, "_latency"}, 32'(lat), 32'd33);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({tag, "_busy_done_overlap"}, 32'(both), 32'd0);
    chk({tag, "_hi"}, md.hi_o, eh);
    chk({tag, "_lo"}, md.lo_o, el);
  endtask
  initial begin
    logic [31:0] lo_prev;
    int seen_done;
    int n;
    md.start_i = 1'b0;
    md.op_i    = 2'b00;
    md.a_i     = '0;
    md.b_i     = '0;
    md.we_hi_i = 1'b0;
    md.we_lo_i = 1'b0;
    md.wd_i    = '0;
    #12;
    chk("rst_busy", 32'(md.busy_o), 32'd0);
    chk("rst_done", 32'(md.done_o), 32'd0);
    chk("rst_hi", md.hi_o, 32'd0);
    chk("rst_lo", md.lo_o, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    // Each op after the first launches in the previous op's done cycle
    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op("mult_neg3x7", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    do_op("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    do_op("mult_5xneg4", 2'b00, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0);
    do_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div_7_neg2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    do_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    do_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, 1'b0);
    do_op("div_neg5_by0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    md.we_hi_i = 1'b1;
    md.wd_i    = 32'h00001234;
    @(posedge clk);
    #1;
    md.we_hi_i = 1'b0;
    chk("mthi_idle", md.hi_o, 32'h00001234);
    // MULTU 100*7, with a start and MTLO attempted mid-run
    @(negedge clk);
    md.start_i = 1'b1;
    md.op_i    = 2'b01;
    md.a_i     = 32'd100;
    md.b_i     = 32'd7;
    @(posedge clk);
    #1;
    md.start_i = 1'b0;
    repeat (5) @(posedge clk);
    lo_prev = md.lo_o;
    @(negedge clk);
    md.start_i = 1'b1;
    md.op_i    = 2'b11;
    md.a_i     = 32'd1;
    md.b_i     = 32'd1;
    md.we_lo_i = 1'b1;
    md.wd_i    = 32'h0000DEAD;
    @(posedge clk);
    #1;
    md.start_i = 1'b0;
    md.we_lo_i = 1'b0;
    chk("mtlo_busy_ignored", md.lo_o, lo_prev);
    n = 0;
    while (!md.done_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_ign_done", 32'(md.done_o), 32'd1);
    chk("busy_ign_hi", md.hi_o, 32'd0);
    chk("busy_ign_lo", md.lo_o, 32'd700);
    seen_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (md.busy_o || md.done_o) seen_done++;
    end
    chk("start_not_queued", 32'(seen_done), 32'd0);
    // Reset 10 cycles into a DIVU: everything clears at once, no done follows
    @(negedge clk);
    md.start_i = 1'b1;
    md.op_i    = 2'b11;
    md.a_i     = 32'd100;
    md.b_i     = 32'd7;
    @(posedge clk);
    #1;
    md.start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n_i = 1'b0;
    #1;
    chk("abort_busy", 32'(md.busy_o), 32'd0);
    chk("abort_hi", md.hi_o, 32'd0);
    chk("abort_lo", md.lo_o, 32'd0);
    seen_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (md.done_o) seen_done++;
    end
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (md.done_o || md.busy_o) seen_done++;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    do_op("after_abort", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
